// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared widths and helpers for the instruction fetch path.
//   ADDR_WIDTH  : byte address width of the fetch PC
//   INSTR_WIDTH : width of one instruction word
//   INSTR_BYTES : PC increment between consecutive instructions
//   ALIGN_OK    : value the two low PC bits must hold for a legal target
package fetch_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [1:0] ALIGN_OK = 2'b00;

    // A fetch target is legal only when it lands on an instruction boundary.
    function automatic logic is_aligned(input logic [ADDR_WIDTH-1:0] addr);
        return addr[1:0] == ALIGN_OK;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Drives the instruction memory address from the fetch PC, waits RD_LATENCY
//   cycles for the combinational read to settle, captures the word into a
//   one-entry buffer and hands it to decode over a valid/ready handshake.
//   Branch redirects reload the PC; a misaligned redirect latches a sticky
//   fault that only Reset clears. Fetching stops once the PC reaches
//   MEM_BYTES.
//
// Ports
//   CLK         in   clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   Address     out  [63:0] instruction memory address (the fetch PC)
//   Data        in   [31:0] instruction word read from memory
//   Instr       out  [31:0] buffered instruction
//   InstrPC     out  [63:0] byte address of Instr
//   InstrValid  out  Instr/InstrPC hold a word not yet taken by decode
//   InstrReady  in   decode accepts the buffered word
//   Redirect    in   one-cycle redirect request
//   RedirectPC  in   [63:0] redirect target
//   Fault       out  sticky misaligned-redirect flag
//   Done        out  program fully fetched and the buffer drained
//
// Handshake: a word moves to decode on a rising edge where InstrValid and
// InstrReady are both high. InstrValid, Instr and InstrPC stay stable until
// that edge (or until a redirect/fault flushes the buffer); InstrReady may be
// driven independently of InstrValid.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0,
    parameter int                    RD_LATENCY = 2,      // must be >= 1
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = 64'h58
) (
    input  logic                   CLK,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  Address,
    input  logic [INSTR_WIDTH-1:0] Data,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [ADDR_WIDTH-1:0]  InstrPC,
    output logic                   InstrValid,
    input  logic                   InstrReady,
    input  logic                   Redirect,
    input  logic [ADDR_WIDTH-1:0]  RedirectPC,
    output logic                   Fault,
    output logic                   Done
);

    localparam int              CW       = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0]   LAT_LAST = CW'(RD_LATENCY - 1);

    logic [ADDR_WIDTH-1:0]  fetch_pc,  fetch_pc_n;
    logic [CW-1:0]          lat_cnt,   lat_cnt_n;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_n;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_n;
    logic                   valid_q,   valid_n;
    logic                   fault_q,   fault_n;

    logic fire;
    logic space;
    logic at_end;

    assign fire   = valid_q & InstrReady;
    assign space  = !valid_q | fire;
    assign at_end = fetch_pc >= MEM_BYTES;

    always_comb begin
        fetch_pc_n = fetch_pc;
        lat_cnt_n  = lat_cnt;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        valid_n    = valid_q;
        fault_n    = fault_q;

        if (fault_q) begin
            // Frozen until Reset; only the buffer is flushed.
            valid_n = 1'b0;
        end else if (Redirect) begin
            // Either way the buffered word is dropped; a same-cycle transfer
            // has already been seen by the consumer.
            valid_n = 1'b0;
            if (!is_aligned(RedirectPC)) begin
                fault_n = 1'b1;
            end else begin
                fetch_pc_n = RedirectPC;
                lat_cnt_n  = '0;
            end
        end else begin
            if (fire) begin
                valid_n = 1'b0;
            end
            if (!at_end) begin
                if (lat_cnt == LAT_LAST && space) begin
                    instr_n    = Data;
                    instr_pc_n = fetch_pc;
                    valid_n    = 1'b1;
                    fetch_pc_n = fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
                    lat_cnt_n  = '0;
                end else if (lat_cnt != LAT_LAST) begin
                    // Counter keeps running while the buffer is full so the
                    // next word is ready the moment space opens up.
                    lat_cnt_n = lat_cnt + CW'(1);
                end
                // Count complete but no space: hold PC so Address stays put.
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_pc   <= RESET_PC;
            lat_cnt    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            lat_cnt    <= lat_cnt_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            valid_q    <= valid_n;
            fault_q    <= fault_n;
        end
    end

    assign Address    = fetch_pc;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = valid_q;
    assign Fault      = fault_q;
    assign Done       = at_end & !valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, RD_LATENCY = 2
    logic        rst = 1'b1;
    logic [63:0] addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        fault;
    logic        done;

    // Second DUT, RD_LATENCY = 1
    logic        rst1 = 1'b1;
    logic [63:0] addr1;
    logic [31:0] data1;
    logic [31:0] instr1;
    logic [63:0] instr_pc1;
    logic        instr_valid1;
    logic        instr_ready1 = 1'b1;
    logic        redirect1 = 1'b0;
    logic [63:0] redirect_pc1 = 64'h0;
    logic        fault1;
    logic        done1;

    // ---------------- instruction memory model ----------------
    logic [31:0] prog [0:31];

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        prog[0]  = 32'hF84003E9; prog[1]  = 32'hF84083EA; prog[2]  = 32'hF84103EB;
        prog[3]  = 32'h8B0A0129; prog[4]  = 32'hCB0B014A; prog[5]  = 32'hF80003E9;
        prog[6]  = 32'hB4000049; prog[7]  = 32'hD1000529; prog[8]  = 32'h8A0A012B;
        prog[9]  = 32'hAA0B014C; prog[10] = 32'h17FFFFFD; prog[11] = 32'hF81083EC;
        prog[12] = 32'hD503201F; prog[13] = 32'h91001129; prog[14] = 32'hF84183ED;
        prog[15] = 32'h8B0D018E; prog[16] = 32'hF80203EE; prog[17] = 32'hCB0E01AF;
        prog[18] = 32'hF84203E9; prog[19] = 32'hB5FFFFA9; prog[20] = 32'hD503201F;
        prog[21] = 32'hF84283EA;
    end

    assign data  = (addr  < 64'h58) ? prog[addr[6:2]]  : 32'h0;
    assign data1 = (addr1 < 64'h58) ? prog[addr1[6:2]] : 32'h0;

    instruction_fetch #(.RESET_PC(64'h0), .RD_LATENCY(2), .MEM_BYTES(64'h58)) u_dut (
        .CLK(clk), .Reset(rst), .Address(addr), .Data(data), .Instr(instr),
        .InstrPC(instr_pc), .InstrValid(instr_valid), .InstrReady(instr_ready),
        .Redirect(redirect), .RedirectPC(redirect_pc), .Fault(fault), .Done(done)
    );

    instruction_fetch #(.RESET_PC(64'h0), .RD_LATENCY(1), .MEM_BYTES(64'h58)) u_dut1 (
        .CLK(clk), .Reset(rst1), .Address(addr1), .Data(data1), .Instr(instr1),
        .InstrPC(instr_pc1), .InstrValid(instr_valid1), .InstrReady(instr_ready1),
        .Redirect(redirect1), .RedirectPC(redirect_pc1), .Fault(fault1), .Done(done1)
    );

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one edge, checks reset outputs, releases at edge+1.
    task automatic do_reset(input logic ready);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        instr_ready = ready;
        tick();
        check("rst_addr",  addr,        64'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr,       32'h0);
        check("rst_pc",    instr_pc,    64'h0);
        check("rst_fault", fault,       1'b0);
        check("rst_done",  done,        1'b0);
        rst = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cyc;
        int last;
        int idx;
        logic seen;

        // Full stream, consumer always ready.
        do_reset(1'b1);
        for (int i = 0; i < 22; i++) exp_q.push_back(prog[i]);
        cyc = 0; last = 0; idx = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            tick();
            cyc++;
            if (instr_valid) begin
                check("stream_instr", instr, exp_q.pop_front());
                check("stream_pc",    instr_pc, 64'(4 * idx));
                check("stream_gap",   64'(cyc - last), 64'd2);
                check("stream_done_low", done, 1'b0);
                last = cyc;
                idx++;
            end
        end
        check("stream_all_seen", 64'(exp_q.size()), 64'd0);
        tick();
        check("drain_done",  done,        1'b1);
        check("drain_valid", instr_valid, 1'b0);
        check("drain_addr",  addr,        64'h58);
        repeat (4) begin
            tick();
            check("after_end_valid", instr_valid, 1'b0);
        end

        // Backpressure: consumer stalls for 5 cycles after first valid.
        do_reset(1'b0);
        tick();
        check("bp_first_edge_valid", instr_valid, 1'b0);
        tick();
        check("bp_valid", instr_valid, 1'b1);
        check("bp_instr", instr,       32'hF84003E9);
        check("bp_pc",    instr_pc,    64'h0);
        check("bp_addr",  addr,        64'h4);
        repeat (5) begin
            tick();
            check("bp_hold_valid", instr_valid, 1'b1);
            check("bp_hold_instr", instr,       32'hF84003E9);
            check("bp_hold_pc",    instr_pc,    64'h0);
            check("bp_hold_addr",  addr,        64'h4);
        end
        instr_ready = 1'b1;
        tick();
        check("bp_next_valid", instr_valid, 1'b1);
        check("bp_next_instr", instr,       32'hF84083EA);
        check("bp_next_pc",    instr_pc,    64'h4);
        check("bp_next_addr",  addr,        64'h8);

        // Asynchronous reset between edges with the counter mid-wait.
        do_reset(1'b0);
        tick();
        tick();
        tick();
        check("ar_pre_addr",  addr,        64'h4);
        check("ar_pre_valid", instr_valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("ar_addr",  addr,        64'h0);
        check("ar_valid", instr_valid, 1'b0);
        check("ar_instr", instr,       32'h0);
        check("ar_pc",    instr_pc,    64'h0);
        check("ar_done",  done,        1'b0);

        // Aligned redirect while 0x08 is buffered.
        do_reset(1'b1);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            tick();
            cyc++;
            if (instr_valid && instr_pc == 64'h8) seen = 1'b1;
        end
        check("rd_reach_0x08", seen, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 64'h28;
        instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
        check("rd_flush_valid", instr_valid, 1'b0);
        check("rd_addr",        addr,        64'h28);
        tick();
        check("rd_wait_valid", instr_valid, 1'b0);
        tick();
        check("rd_valid", instr_valid, 1'b1);
        check("rd_instr", instr,       32'h17FFFFFD);
        check("rd_pc",    instr_pc,    64'h28);
        check("rd_next_addr", addr,    64'h2C);

        // Misaligned redirect: sticky fault, nothing fetched until reset.
        do_reset(1'b0);
        tick();
        tick();
        check("mf_pre_valid", instr_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 64'h22;
        tick();
        redirect = 1'b0;
        check("mf_fault", fault,       1'b1);
        check("mf_valid", instr_valid, 1'b0);
        check("mf_addr",  addr,        64'h4);
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            // An aligned redirect mid-fault must be ignored.
            redirect    = (i == 3);
            redirect_pc = 64'h10;
            tick();
            check("mf_hold_valid", instr_valid, 1'b0);
            check("mf_hold_fault", fault,       1'b1);
            check("mf_hold_addr",  addr,        64'h4);
        end
        redirect = 1'b0;
        do_reset(1'b1);
        tick();
        tick();
        check("mf_restart_valid", instr_valid, 1'b1);
        check("mf_restart_instr", instr,       32'hF84003E9);
        check("mf_restart_pc",    instr_pc,    64'h0);

        // RD_LATENCY = 1: one word per cycle, valid continuously high.
        instr_ready1 = 1'b1;
        rst1 = 1'b1;
        tick();
        check("l1_rst_valid", instr_valid1, 1'b0);
        check("l1_rst_addr",  addr1,        64'h0);
        rst1 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick();
            check("l1_valid", instr_valid1, 1'b1);
            check("l1_instr", instr1,       prog[i]);
            check("l1_pc",    instr_pc1,    64'(4 * i));
        end
        tick();
        check("l1_end_valid", instr_valid1, 1'b0);
        check("l1_end_done",  done1,        1'b1);
        check("l1_fault",     fault1,       1'b0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
